// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - in-order write-back queue with bypass lookup for a 32x32 register file
//
// Ports:
//   clk_port, rst_port            clock, synchronous active-high reset
//   req0_* / req1_*               ALU / load write-back requests (valid, addr, data)
//   req_ready                     both request ports may fire this cycle
//   wr, address_d, data_d         register file write port, driven from the queue head
//   look_addr_a/b -> look_hit_a/b, look_data_a/b   newest-first bypass lookups
//   count, empty                  occupancy
module regfile_write_queue #(
    parameter int N     = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk_port,
    input  logic                       rst_port,
    input  logic                       req0_valid,
    input  logic [AW-1:0]              req0_addr,
    input  logic [N-1:0]               req0_data,
    input  logic                       req1_valid,
    input  logic [AW-1:0]              req1_addr,
    input  logic [N-1:0]               req1_data,
    output logic                       req_ready,
    output logic                       wr,
    output logic [AW-1:0]              address_d,
    output logic [N-1:0]               data_d,
    input  logic [AW-1:0]              look_addr_a,
    output logic                       look_hit_a,
    output logic [N-1:0]               look_data_a,
    input  logic [AW-1:0]              look_addr_b,
    output logic                       look_hit_b,
    output logic [N-1:0]               look_data_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [N-1:0]  data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push0, push1, pop;
    logic [PW-1:0] slot1;

    // Ready only looks at registered occupancy, so it never depends on *_valid.
    assign req_ready = (CW'(DEPTH) - count_q) >= CW'(2);

    // Requests to $0 are accepted but never enqueued.
    assign push0 = req0_valid && req_ready && (req0_addr != '0);
    assign push1 = req1_valid && req_ready && (req1_addr != '0);
    assign pop   = (count_q != '0);

    // Port 1 lands behind port 0 when both push, otherwise at the tail.
    assign slot1 = push0 ? wr_ptr_q + PW'(1) : wr_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk_port) begin
        if (rst_port) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push0) begin
                addr_q[wr_ptr_q] <= req0_addr;
                data_q[wr_ptr_q] <= req0_data;
            end
            if (push1) begin
                addr_q[slot1] <= req1_addr;
                data_q[slot1] <= req1_data;
            end
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign wr    = !empty;

    always_comb begin
        address_d = '0;
        data_d    = '0;
        if (wr) begin
            address_d = addr_q[rd_ptr_q];
            data_d    = data_q[rd_ptr_q];
        end
    end

    // Walk occupied entries oldest to youngest; later matches overwrite earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        look_hit_a  = 1'b0;
        look_data_a = '0;
        look_hit_b  = 1'b0;
        look_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (look_addr_a != '0 && addr_q[idx] == look_addr_a) begin
                    look_hit_a  = 1'b1;
                    look_data_a = data_q[idx];
                end
                if (look_addr_b != '0 && addr_q[idx] == look_addr_b) begin
                    look_hit_b  = 1'b1;
                    look_data_b = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed and randomized checks of regfile_write_queue against a reference model
module tb_regfile_write_queue;
    logic        clk_port = 1'b0;
    logic        rst_port;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req_ready, wr;
    logic [4:0]  address_d;
    logic [31:0] data_d;
    logic [4:0]  look_addr_a, look_addr_b;
    logic        look_hit_a, look_hit_b;
    logic [31:0] look_data_a, look_data_b;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int passed = 0;

    regfile_write_queue #(.N(32), .AW(5), .DEPTH(4)) dut (
        .clk_port(clk_port), .rst_port(rst_port),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req_ready(req_ready), .wr(wr), .address_d(address_d), .data_d(data_d),
        .look_addr_a(look_addr_a), .look_hit_a(look_hit_a), .look_data_a(look_data_a),
        .look_addr_b(look_addr_b), .look_hit_b(look_hit_b), .look_data_b(look_data_b),
        .count(count), .empty(empty)
    );

    always #5 clk_port = ~clk_port;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_port);
        #1;
    endtask

    task automatic req(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    task automatic idle();
        req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reference model state for the random phase.
    logic [4:0]  q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] rf_model[32];
    logic [31:0] rf_dut[32];

    task automatic model_look(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (a != 5'd0) begin
            for (int i = q_addr.size() - 1; i >= 0; i--) begin
                if (q_addr[i] == a) begin
                    hit = 1'b1;
                    d   = q_data[i];
                    break;
                end
            end
        end
    endtask

    initial begin
        logic        mhit;
        logic [31:0] mdata;
        logic        ready_m, f0, f1;
        int          wraps;

        rst_port = 1'b1;
        idle();
        look_addr_a = 5'd0;
        look_addr_b = 5'd0;
        step();
        step();
        rst_port = 1'b0;
        #1;
        chk("reset_wr", wr, 1'b0);
        chk("reset_count", count, 3'd0);
        chk("reset_empty", empty, 1'b1);
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_hit_a", look_hit_a, 1'b0);
        chk("reset_hit_b", look_hit_b, 1'b0);

        // Single ALU write: visible on the write port the cycle after it fires.
        req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        step();
        idle();
        #1;
        chk("t1_wr", wr, 1'b1);
        chk("t1_addr", address_d, 5'd5);
        chk("t1_data", data_d, 32'hDEADBEEF);
        step();
        chk("t1_wr_after", wr, 1'b0);
        chk("t1_empty_after", empty, 1'b1);
        chk("t1_addr_zero", address_d, 5'd0);
        chk("t1_data_zero", data_d, 32'd0);

        // Same destination on both ports: port 0 first, port 1 wins the lookup.
        req(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
        step();
        idle();
        look_addr_a = 5'd3;
        look_addr_b = 5'd4;
        #1;
        chk("t2_count", count, 3'd2);
        chk("t2_hit_a", look_hit_a, 1'b1);
        chk("t2_look_a", look_data_a, 32'h2);
        chk("t2_hit_b", look_hit_b, 1'b0);
        chk("t2_look_b", look_data_b, 32'h0);
        chk("t2_first_addr", address_d, 5'd3);
        chk("t2_first_data", data_d, 32'h1);
        step();
        chk("t2_second_data", data_d, 32'h2);
        chk("t2_look_a_tail", look_data_a, 32'h2);
        step();
        chk("t2_drained", empty, 1'b1);
        chk("t2_no_hit", look_hit_a, 1'b0);

        // Two back-to-back dual pushes fill to 3 and drop ready.
        req(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0);
        step();
        chk("t3_count1", count, 3'd2);
        chk("t3_ready1", req_ready, 1'b1);
        chk("t3_head1", address_d, 5'd10);
        req(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0);
        step();
        chk("t3_count2", count, 3'd3);
        chk("t3_ready2", req_ready, 1'b0);
        chk("t3_head2", address_d, 5'd11);
        req(1'b1, 5'd14, 32'hE0, 1'b1, 5'd15, 32'hF0);
        step();
        idle();
        #1;
        chk("t3_count3", count, 3'd2);
        chk("t3_head3", address_d, 5'd12);
        chk("t3_head3_data", data_d, 32'hC0);
        step();
        chk("t3_head4", address_d, 5'd13);
        chk("t3_head4_data", data_d, 32'hD0);
        step();
        chk("t3_drained", empty, 1'b1);

        // Writes to $0 are swallowed.
        req(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        look_addr_a = 5'd0;
        step();
        idle();
        #1;
        chk("t4_count", count, 3'd0);
        chk("t4_wr", wr, 1'b0);
        chk("t4_hit_a", look_hit_a, 1'b0);

        // Reset while occupied and while requests are presented.
        req(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        step();
        req(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
        step();
        chk("t5_count_pre", count, 3'd3);
        rst_port = 1'b1;
        step();
        rst_port = 1'b0;
        idle();
        #1;
        chk("t5_count", count, 3'd0);
        chk("t5_wr", wr, 1'b0);
        chk("t5_empty", empty, 1'b1);
        step();
        chk("t5_wr_later", wr, 1'b0);

        // Random stream against a queue + register file model.
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = 32'd0;
            rf_dut[i]   = 32'd0;
        end
        wraps = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            look_addr_a = 5'($urandom_range(0, 31));
            look_addr_b = (cyc % 3 == 0) ? 5'd0 : 5'($urandom_range(0, 7));
            #1;
            ready_m = (4 - q_addr.size()) >= 2;
            if (wr !== (q_addr.size() != 0) || count !== 3'(q_addr.size()) || req_ready !== ready_m)
                chk("rnd_ctrl", {wr, count, req_ready}, {q_addr.size() != 0, 3'(q_addr.size()), ready_m});
            if (q_addr.size() != 0 && (address_d !== q_addr[0] || data_d !== q_data[0]))
                chk("rnd_head", {address_d, data_d}, {q_addr[0], q_data[0]});
            model_look(look_addr_a, mhit, mdata);
            if (look_hit_a !== mhit || look_data_a !== mdata)
                chk("rnd_look_a", {look_hit_a, look_data_a}, {mhit, mdata});
            model_look(look_addr_b, mhit, mdata);
            if (look_hit_b !== mhit || look_data_b !== mdata)
                chk("rnd_look_b", {look_hit_b, look_data_b}, {mhit, mdata});
            if (wr === 1'b1) rf_dut[address_d] = data_d;

            req($urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 99) < 50, 5'($urandom_range(0, 15)), $urandom);
            if (q_addr.size() != 0) begin
                rf_model[q_addr[0]] = q_data[0];
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                wraps++;
            end
            f0 = req0_valid && ready_m && req0_addr != 5'd0;
            f1 = req1_valid && ready_m && req1_addr != 5'd0;
            if (f0) begin q_addr.push_back(req0_addr); q_data.push_back(req0_data); end
            if (f1) begin q_addr.push_back(req1_addr); q_data.push_back(req1_data); end
            step();
        end
        idle();
        for (int k = 0; k < 8; k++) begin
            if (wr === 1'b1) rf_dut[address_d] = data_d;
            if (q_addr.size() != 0) begin
                rf_model[q_addr[0]] = q_data[0];
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            step();
        end
        chk("rnd_drained", empty, 1'b1);
        chk("rnd_pointer_wrapped", wraps > 8, 1'b1);
        for (int r = 0; r < 32; r++)
            chk($sformatf("rf_final_%0d", r), rf_dut[r], rf_model[r]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
